// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit : fetches ROM words at the core PC, issues one per 3 cycles
// Revision 1.0
// ============================================================================
module inst_fetch_unit #(
    parameter int IMEM_DEPTH = 1024,
    parameter int AW         = 10,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] exec_num_i,
    input  logic [31:0]      inst_addr_i,
    output logic             imem_en_o,
    output logic [AW-1:0]    imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic             in_valid_o,
    output logic [31:0]      inst_o,
    output logic [CNT_W-1:0] issued_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             in_valid_q;
    logic [31:0]      inst_q;
    logic             done_q;
    logic             err_q;
    logic             addr_fault;

    assign addr_fault = (inst_addr_i[1:0] != 2'b00) ||
                        ({2'b00, inst_addr_i[31:2]} >= DEPTH_W);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        issued_d    = issued_q;
        imem_en_o   = 1'b0;
        imem_addr_o = '0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    target_d = exec_num_i;
                    issued_d = '0;
                    state_d  = (exec_num_i == '0) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (addr_fault) begin
                    state_d = S_ERR;
                end else begin
                    imem_en_o   = 1'b1;
                    imem_addr_o = inst_addr_i[AW+1:2];
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                // Saturate so an issued count can never wrap past the target
                if (issued_q != target_q) begin
                    issued_d = issued_q + CNT_W'(1);
                end
                state_d = ((issued_q + CNT_W'(1)) == target_q) ? S_DONE : S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            issued_q   <= '0;
            in_valid_q <= 1'b0;
            inst_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            issued_q   <= issued_d;
            // The captured word is only ever held for the ISSUE cycle
            in_valid_q <= (state_q == S_FETCH);
            inst_q     <= (state_q == S_FETCH) ? imem_rdata_i : 32'h0;
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
        end
    end

    assign in_valid_o = in_valid_q;
    assign inst_o     = inst_q;
    assign issued_o   = issued_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_unit : vector table, directed runs and random runs vs timeline model
// Revision 1.0
// ============================================================================
module tb_inst_fetch_unit;

    localparam int IMEM_DEPTH = 1024;
    localparam int AW         = 10;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] exec_num;
    logic [31:0]      inst_addr;
    logic             imem_en;
    logic [AW-1:0]    imem_addr;
    logic [31:0]      imem_rdata;
    logic             in_valid;
    logic [31:0]      inst;
    logic [CNT_W-1:0] issued;
    logic             done;
    logic             err;

    logic [31:0] rom [IMEM_DEPTH];
    logic [31:0] pcs [8];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.IMEM_DEPTH(IMEM_DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .exec_num_i   (exec_num),
        .inst_addr_i  (inst_addr),
        .imem_en_o    (imem_en),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .in_valid_o   (in_valid),
        .inst_o       (inst),
        .issued_o     (issued),
        .done_o       (done),
        .err_o        (err)
    );

    typedef struct {
        logic        start;
        logic [15:0] n;
        logic [31:0] pc;
        logic        en;
        logic [9:0]  a;
        logic        v;
        logic [31:0] inst;
        logic [15:0] iss;
        logic        dn;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    task automatic expect_out(input string tag, input bit e_en, input logic [31:0] e_a,
                              input bit e_v, input logic [31:0] e_inst, input int e_iss,
                              input bit e_dn, input bit e_er);
        chk({tag, ".imem_en"},   32'(imem_en),   32'(e_en));
        chk({tag, ".imem_addr"}, 32'(imem_addr), e_a);
        chk({tag, ".in_valid"},  32'(in_valid),  32'(e_v));
        chk({tag, ".inst"},      inst,           e_inst);
        chk({tag, ".issued"},    32'(issued),    32'(e_iss));
        chk({tag, ".done"},      32'(done),      32'(e_dn));
        chk({tag, ".err"},       32'(err),       32'(e_er));
    endtask

    // Clock edge plus a synchronous ROM: data appears the cycle after a read enable
    task automatic tick();
        logic          en_s;
        logic [AW-1:0] a_s;
        en_s = imem_en;
        a_s  = imem_addr;
        @(posedge clk);
        #1;
        if (en_s) imem_rdata = rom[a_s];
        else      imem_rdata = $urandom;
    endtask

    function automatic bit bad_pc(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= IMEM_DEPTH);
    endfunction

    // Run of n instructions; the core presents pcs[k] for instruction k.
    // Expected behaviour is a timeline: instruction k occupies cycles 3k+1..3k+3.
    task automatic run_check(input string tag, input int n, input bit glitch);
        int f, m, k, ph, last;
        f = n;
        for (int i = n - 1; i >= 0; i--) if (bad_pc(pcs[i])) f = i;
        m = (f < n) ? f : n;
        last = (f < n) ? 3 * f + 5 : 3 * n + 3;
        start = 1'b1;
        exec_num = CNT_W'(n);
        inst_addr = pcs[0];
        #1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            k  = (c - 1) / 3;
            ph = (c - 1) % 3;
            if (k < n) inst_addr = pcs[k];
            start = glitch && (c <= 3 * m);
            if (start) exec_num = CNT_W'($urandom_range(0, 9));
            #1;
            if (c <= 3 * m)
                expect_out(tag, ph == 0, (ph == 0) ? 32'(pcs[k] / 4) : 32'h0, ph == 2,
                           (ph == 2) ? rom[pcs[k] / 4] : 32'h0, k, 1'b0, 1'b0);
            else if (f < n)
                expect_out(tag, 1'b0, 32'h0, 1'b0, 32'h0, f, 1'b0, c != 3 * f + 1);
            else
                expect_out(tag, 1'b0, 32'h0, 1'b0, 32'h0, n, 1'b1, 1'b0);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'd4, 32'd0,  1'b0, 10'd0, 1'b0, 32'h0,        16'd0, 1'b0};
        tbl[1]  = '{1'b0, 16'd0, 32'd0,  1'b1, 10'd0, 1'b0, 32'h0,        16'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'd0, 32'd0,  1'b0, 10'd0, 1'b0, 32'h0,        16'd0, 1'b0};
        tbl[3]  = '{1'b0, 16'd0, 32'd0,  1'b0, 10'd0, 1'b1, 32'h20010005, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 16'd0, 32'd4,  1'b1, 10'd1, 1'b0, 32'h0,        16'd1, 1'b0};
        tbl[5]  = '{1'b0, 16'd0, 32'd4,  1'b0, 10'd0, 1'b0, 32'h0,        16'd1, 1'b0};
        tbl[6]  = '{1'b0, 16'd0, 32'd4,  1'b0, 10'd0, 1'b1, 32'h20020003, 16'd1, 1'b0};
        tbl[7]  = '{1'b0, 16'd0, 32'd8,  1'b1, 10'd2, 1'b0, 32'h0,        16'd2, 1'b0};
        tbl[8]  = '{1'b0, 16'd0, 32'd8,  1'b0, 10'd0, 1'b0, 32'h0,        16'd2, 1'b0};
        tbl[9]  = '{1'b0, 16'd0, 32'd8,  1'b0, 10'd0, 1'b1, 32'h00221820, 16'd2, 1'b0};
        tbl[10] = '{1'b0, 16'd0, 32'd12, 1'b1, 10'd3, 1'b0, 32'h0,        16'd3, 1'b0};
        tbl[11] = '{1'b0, 16'd0, 32'd12, 1'b0, 10'd0, 1'b0, 32'h0,        16'd3, 1'b0};
        tbl[12] = '{1'b0, 16'd0, 32'd12, 1'b0, 10'd0, 1'b1, 32'hAC030000, 16'd3, 1'b0};
        tbl[13] = '{1'b0, 16'd0, 32'd12, 1'b0, 10'd0, 1'b0, 32'h0,        16'd4, 1'b1};
        tbl[14] = '{1'b0, 16'd0, 32'd12, 1'b0, 10'd0, 1'b0, 32'h0,        16'd4, 1'b1};

        for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = $urandom;
        rom[0] = 32'h20010005;
        rom[1] = 32'h20020003;
        rom[2] = 32'h00221820;
        rom[3] = 32'hAC030000;
        rom[4] = 32'h8C040008;

        rst_n = 1'b0;
        start = 1'b0;
        exec_num = '0;
        inst_addr = '0;
        imem_rdata = '0;
        tick();
        tick();
        expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("idle", 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Four sequential instructions, cycle by cycle
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start;
            exec_num = tbl[i].n;
            inst_addr = tbl[i].pc;
            #1;
            expect_out($sformatf("vec%0d", i), tbl[i].en, 32'(tbl[i].a), tbl[i].v,
                       tbl[i].inst, 32'(tbl[i].iss), tbl[i].dn, 1'b0);
            tick();
        end
        start = 1'b0;

        pcs[0] = 32'h0;  pcs[1] = 32'h10;
        run_check("branch", 2, 1'b0);
        pcs[0] = 32'h6;
        run_check("misalign", 1, 1'b0);
        pcs[0] = 32'h0;  pcs[1] = 32'h4;
        run_check("recover", 2, 1'b0);
        pcs[0] = 32'h0;  pcs[1] = 32'(IMEM_DEPTH * 4);  pcs[2] = 32'h8;
        run_check("range", 3, 1'b0);
        pcs[0] = 32'h0;
        run_check("zero", 0, 1'b0);
        pcs[0] = 32'(IMEM_DEPTH * 4 - 4);  pcs[1] = 32'h0;  pcs[2] = 32'h4;
        run_check("lastword", 3, 1'b1);

        // Reset during FETCH of the second instruction; start pulses in between are ignored
        start = 1'b1;  exec_num = 16'd3;  inst_addr = 32'h0;  #1;
        tick();
        start = 1'b0;  #1;
        expect_out("rst.c1", 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        tick();
        start = 1'b1;  exec_num = 16'd1;  #1;
        expect_out("rst.c2", 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        tick();
        start = 1'b0;  #1;
        expect_out("rst.c3", 1'b0, 32'h0, 1'b1, rom[0], 0, 1'b0, 1'b0);
        tick();
        inst_addr = 32'h4;  #1;
        expect_out("rst.c4", 1'b1, 32'h1, 1'b0, 32'h0, 1, 1'b0, 1'b0);
        tick();
        start = 1'b1;  rst_n = 1'b0;  #1;
        expect_out("rst.c5", 1'b0, 32'h0, 1'b0, 32'h0, 1, 1'b0, 1'b0);
        tick();
        start = 1'b0;  #1;
        expect_out("rst.after", 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("rst.idle", 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0);
        end

        // Random runs: mostly sequential PCs with jumps and occasional faults
        for (int r = 0; r < 25; r++) begin
            int n, sel;
            n = $urandom_range(0, 6);
            pcs[0] = 32'($urandom_range(0, IMEM_DEPTH - 1)) << 2;
            for (int k = 1; k < 8; k++) begin
                sel = $urandom_range(0, 19);
                if (sel < 14)       pcs[k] = pcs[k-1] + 32'd4;
                else if (sel < 18)  pcs[k] = 32'($urandom_range(0, IMEM_DEPTH - 1)) << 2;
                else if (sel == 18) pcs[k] = (32'($urandom_range(0, IMEM_DEPTH - 1)) << 2)
                                             + 32'($urandom_range(1, 3));
                else                pcs[k] = 32'($urandom_range(IMEM_DEPTH, 32'h3FFF_FFFF)) << 2;
            end
            run_check($sformatf("rand%0d", r), n, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
